// File: rtl/rgb_pwm_driver_pkg.sv
// rgb_pkg: shared duty types and channel indices for the RGB PWM path
package rgb_pkg;
    localparam int RES = 8;
    localparam int CH_R = 0;
    localparam int CH_G = 1;
    localparam int CH_B = 2;
    typedef logic [RES-1:0] duty_t;
    typedef struct packed {
        duty_t r;
        duty_t g;
        duty_t b;
    } rgb_duty_t;
endpackage

// File: rtl/rgb_pwm_driver_if.sv
// rgb_pwm_driver_if: valid/ready duty transfer from a colour source to the PWM driver
interface rgb_pwm_driver_if #(parameter int RES = rgb_pkg::RES);
    logic           duty_valid;
    logic           duty_ready;
    logic [RES-1:0] duty_r;
    logic [RES-1:0] duty_g;
    logic [RES-1:0] duty_b;
    modport master (output duty_valid, duty_r, duty_g, duty_b, input duty_ready);
    modport slave (input duty_valid, duty_r, duty_g, duty_b, output duty_ready);
endinterface

// File: rtl/rgb_pwm_driver_pwm_channel.sv
// pwm_channel: registered compare of the shared frame counter against one active duty
module pwm_channel #(
    parameter int RES      = 8,
    parameter bit ACT_HIGH = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic [RES-1:0] cnt,
    input  logic [RES-1:0] duty,
    output logic           pwm
);
    always_ff @(posedge clk or negedge reset)
        if (!reset) pwm <= ~ACT_HIGH;
        else        pwm <= (enable && cnt < duty) ? ACT_HIGH : ~ACT_HIGH;
endmodule

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: three-channel PWM with double-buffered duties applied at frame boundaries
module rgb_pwm_driver
    import rgb_pkg::*;
#(
    parameter int RES      = rgb_pkg::RES,
    parameter bit ACT_HIGH = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              enable,
    rgb_pwm_driver_if.slave   duty,
    output logic              pwm_r,
    output logic              pwm_g,
    output logic              pwm_b,
    output logic              frame_start
);
    localparam logic [RES-1:0] CNT_MAX = {{(RES-1){1'b1}}, 1'b0};
    logic [RES-1:0] cnt;
    logic [RES-1:0] act [3];
    logic [RES-1:0] pend [3];
    logic [RES-1:0] din [3];
    logic           pend_full;
    logic           accept;
    logic           boundary;
    logic [2:0]     pwm;
    assign duty.duty_ready = ~pend_full;
    assign accept   = duty.duty_valid && !pend_full;
    assign boundary = enable && tick && cnt == CNT_MAX;
    assign din[CH_R] = duty.duty_r;
    assign din[CH_G] = duty.duty_g;
    assign din[CH_B] = duty.duty_b;
    // accept and apply are exclusive: apply needs a full buffer, accept an empty one
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            cnt         <= '0;
            frame_start <= 1'b0;
            pend_full   <= 1'b0;
            act         <= '{default: '0};
            pend        <= '{default: '0};
        end else begin
            cnt         <= !enable ? '0 : tick ? (boundary ? '0 : cnt + 1'b1) : cnt;
            frame_start <= boundary;
            if (accept) begin
                pend      <= din;
                pend_full <= 1'b1;
            end else if (boundary && pend_full) begin
                act       <= pend;
                pend_full <= 1'b0;
            end
        end
    for (genvar c = 0; c < 3; c++) begin : g_ch
        pwm_channel #(.RES(RES), .ACT_HIGH(ACT_HIGH)) u_ch (
            .clk    (clk),
            .reset  (reset),
            .enable (enable),
            .cnt    (cnt),
            .duty   (act[c]),
            .pwm    (pwm[c])
        );
    end
    assign pwm_r = pwm[CH_R];
    assign pwm_g = pwm[CH_G];
    assign pwm_b = pwm[CH_B];
endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb_rgb_pwm_driver: per-frame on-count scoreboard for active-high and active-low builds
module tb_rgb_pwm_driver;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tick = 1'b0;
    logic enable = 1'b1;
    logic v = 1'b0;
    logic [7:0] dr = '0, dg = '0, db = '0;
    logic pwm_r, pwm_g, pwm_b, fs;
    logic pwm_nr, pwm_ng, pwm_nb, fs_n;
    logic mon_en = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    logic [26:0] exp_q [$];

    rgb_pwm_driver_if #(.RES(8)) bus ();
    rgb_pwm_driver_if #(.RES(8)) bus_n ();
    assign bus.duty_valid = v;
    assign bus.duty_r = dr;
    assign bus.duty_g = dg;
    assign bus.duty_b = db;
    assign bus_n.duty_valid = v;
    assign bus_n.duty_r = dr;
    assign bus_n.duty_g = dg;
    assign bus_n.duty_b = db;

    rgb_pwm_driver #(.RES(8), .ACT_HIGH(1'b1)) dut (
        .clk(clk), .reset(reset), .tick(tick), .enable(enable), .duty(bus),
        .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b), .frame_start(fs)
    );
    rgb_pwm_driver #(.RES(8), .ACT_HIGH(1'b0)) dut_n (
        .clk(clk), .reset(reset), .tick(tick), .enable(enable), .duty(bus_n),
        .pwm_r(pwm_nr), .pwm_g(pwm_ng), .pwm_b(pwm_nb), .frame_start(fs_n)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endfunction

    function automatic logic [26:0] ex(int r, int g, int b);
        return {9'(r), 9'(g), 9'(b)};
    endfunction

    // monitor: count on-samples per window between frame_start pulses, compare with queue head
    int cr = 0, cg = 0, cb = 0, nr = 0, ng = 0, nb = 0, len = 0;
    always @(negedge clk) begin
        if (!mon_en) begin
            cr = 0; cg = 0; cb = 0; nr = 0; ng = 0; nb = 0; len = 0;
        end else begin
            cr += int'(pwm_r); cg += int'(pwm_g); cb += int'(pwm_b);
            nr += int'(!pwm_nr); ng += int'(!pwm_ng); nb += int'(!pwm_nb);
            len++;
            if (fs) begin
                if (exp_q.size() == 0) chk("frame_unexpected", 1, 0);
                else begin
                    logic [26:0] e;
                    e = exp_q.pop_front();
                    chk("frame_duty", {5'd0, 9'(cr), 9'(cg), 9'(cb)}, {5'd0, e});
                    chk("frame_duty_inv", {5'd0, 9'(nr), 9'(ng), 9'(nb)}, {5'd0, e});
                    chk("frame_len", len, 255);
                    chk("frame_start_inv", fs_n, 1);
                end
                cr = 0; cg = 0; cb = 0; nr = 0; ng = 0; nb = 0; len = 0;
            end
        end
    end

    task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        v = 1'b1; dr = r; dg = g; db = b;
        while (!bus.duty_ready && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", bus.duty_ready, 1);
        @(negedge clk);
        v = 1'b0;
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fs && n < 600);
        if (!fs) chk("frame_start_timeout", 0, 1);
    endtask

    initial begin
        int n;
        logic prev;
        #300000;
        $display("FAIL global_timeout: got %0d expected %0d", 0, 1);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic prev;
        // reset held with tick toggling
        repeat (4) begin
            @(negedge clk);
            tick = ~tick;
        end
        chk("rst_pwm", {pwm_r, pwm_g, pwm_b}, 0);
        chk("rst_pwm_inv", {pwm_nr, pwm_ng, pwm_nb}, 3'b111);
        chk("rst_cnt", dut.cnt, 0);
        chk("rst_fs", fs, 0);
        tick = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ready", bus.duty_ready, 1);
        // basic duties: frame 1 runs with zero duties, loaded values from frame 2
        send(8'd64, 8'd128, 8'd0);
        chk("pend_ready_low", bus.duty_ready, 0);
        exp_q.push_back(ex(0, 0, 0));
        exp_q.push_back(ex(64, 128, 0));
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1 mon_en = 1'b1;
        wait_fs(n);
        chk("ready_after_apply", bus.duty_ready, 1);
        // extremes
        send(8'd255, 8'd0, 8'd255);
        exp_q.push_back(ex(255, 0, 255));
        exp_q.push_back(ex(255, 0, 255));
        wait_fs(n);
        wait_fs(n);
        // double buffer mid-frame, second valid ignored while not ready
        repeat (50) @(negedge clk);
        send(8'd200, 8'd200, 8'd200);
        exp_q.push_back(ex(200, 200, 200));
        chk("db_ready_low", bus.duty_ready, 0);
        v = 1'b1; dr = 8'd10; dg = 8'd10; db = 8'd10;
        repeat (5) @(negedge clk);
        v = 1'b0;
        prev = bus.duty_ready;
        n = 0;
        do begin
            prev = bus.duty_ready;
            @(negedge clk);
            n++;
        end while (!fs && n < 600);
        chk("ready_pre_boundary", prev, 0);
        chk("ready_post_boundary", bus.duty_ready, 1);
        // collision: accept on the boundary clk is deferred one frame
        repeat (254) @(negedge clk);
        chk("cnt_pre_collision", dut.cnt, 254);
        exp_q.push_back(ex(200, 200, 200));
        exp_q.push_back(ex(150, 60, 250));
        v = 1'b1; dr = 8'd150; dg = 8'd60; db = 8'd250;
        @(negedge clk);
        v = 1'b0;
        chk("collision_fs", fs, 1);
        chk("collision_ready", bus.duty_ready, 0);
        wait_fs(n);
        wait_fs(n);
        // enable drop at cnt=100
        repeat (100) @(negedge clk);
        chk("cnt_100", dut.cnt, 100);
        chk("pwm_b_on", pwm_b, 1);
        enable = 1'b0;
        mon_en = 1'b0;
        @(negedge clk);
        chk("dis_pwm", {pwm_r, pwm_g, pwm_b}, 0);
        chk("dis_pwm_inv", {pwm_nr, pwm_ng, pwm_nb}, 3'b111);
        chk("dis_cnt", dut.cnt, 0);
        send(8'd5, 8'd5, 8'd5);
        chk("dis_accept", bus.duty_ready, 0);
        repeat (20) @(negedge clk);
        chk("dis_cnt_hold", dut.cnt, 0);
        chk("dis_fs", fs, 0);
        exp_q.push_back(ex(150, 60, 250));
        exp_q.push_back(ex(5, 5, 5));
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        #1 mon_en = 1'b1;
        wait_fs(n);
        chk("reenable_first_fs", n, 255);
        wait_fs(n);
        // async reset mid-frame with pending data
        repeat (50) @(negedge clk);
        send(8'd77, 8'd77, 8'd77);
        chk("pre_rst_ready", bus.duty_ready, 0);
        mon_en = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("arst_pwm", {pwm_r, pwm_g, pwm_b}, 0);
        chk("arst_pwm_inv", {pwm_nr, pwm_ng, pwm_nb}, 3'b111);
        chk("arst_cnt", dut.cnt, 0);
        chk("arst_fs", fs, 0);
        chk("arst_ready", bus.duty_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        exp_q.push_back(ex(0, 0, 0));
        @(posedge clk);
        #1 mon_en = 1'b1;
        wait_fs(n);
        chk("post_rst_ready", bus.duty_ready, 1);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
